reservation_station: RTL and testbench

Single-functional-unit reservation station that sits between dispatch and the issue unit. It buffers dispatched instructions, snoops the CDB to capture source operands, and drives `insn_ready` for its FU lane. It also accepts the per-lane issue strobe and presents the oldest ready instruction's payload to the functional unit. It is the responder side of the issue-unit handshake: one instance per FU lane (LSU, MULT, BTU, ALU).

---
 rtl/reservation_station.sv | 156 +++++++++++++++
 tb/tb_reservation_station.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reservation_station.sv
// reservation_station: single-FU-lane reservation station built as a collapsing
// queue (entry 0 is oldest). Buffers dispatched instructions, captures source
// operands from the CDB, and presents the oldest ready entry to the issue unit.
// Optional feature macro: RS_DISPATCH_BYPASS_EN (CDB-to-dispatch operand bypass).

`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

module reservation_station #(
   parameter int RS_SIZE  = 4,
   parameter int TAG_LEN  = `ROB_TAG_LEN,
   parameter int DATA_LEN = 32,
   parameter int FUNC_LEN = 5
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                squash,
   input  logic                dispatch_valid,
   input  logic [TAG_LEN-1:0]  dispatch_rob_tag,
   input  logic [FUNC_LEN-1:0] dispatch_func,
   input  logic                dispatch_src1_valid,
   input  logic [DATA_LEN-1:0] dispatch_src1_value,
   input  logic [TAG_LEN-1:0]  dispatch_src1_tag,
   input  logic                dispatch_src2_valid,
   input  logic [DATA_LEN-1:0] dispatch_src2_value,
   input  logic [TAG_LEN-1:0]  dispatch_src2_tag,
   output logic                rs_full,
   input  logic                cdb_valid,
   input  logic [TAG_LEN-1:0]  cdb_tag,
   input  logic [DATA_LEN-1:0] cdb_value,
   output logic                insn_ready,
   input  logic                issue,
   output logic [TAG_LEN-1:0]  issue_rob_tag,
   output logic [FUNC_LEN-1:0] issue_func,
   output logic [DATA_LEN-1:0] issue_src1,
   output logic [DATA_LEN-1:0] issue_src2
);

   localparam int CW = $clog2(RS_SIZE + 1);
   localparam int IW = $clog2(RS_SIZE);

   typedef struct packed {
      logic                valid;
      logic [TAG_LEN-1:0]  rob_tag;
      logic [FUNC_LEN-1:0] func;
      logic                src1_valid;
      logic [DATA_LEN-1:0] src1_value;
      logic [TAG_LEN-1:0]  src1_tag;
      logic                src2_valid;
      logic [DATA_LEN-1:0] src2_value;
      logic [TAG_LEN-1:0]  src2_tag;
   } entry_t;

   entry_t              entries      [RS_SIZE];
   entry_t              entries_up   [RS_SIZE];  // entries[i+1], empty past the top
   entry_t              entries_next [RS_SIZE];
   entry_t              disp_entry;
   entry_t              sel_entry;
   logic [CW-1:0]       count;
   logic [CW-1:0]       count_after_issue;
   logic [CW-1:0]       count_next;
   logic [RS_SIZE-1:0]  ready;
   logic [IW-1:0]       sel_idx;
   logic                issue_fire;
   logic                dispatch_ok;

   // Shift source for the collapse: each slot looks at the slot above it.
   for (genvar g = 0; g < RS_SIZE; g++) begin : g_up
      if (g < RS_SIZE - 1) begin : g_mid
         assign entries_up[g] = entries[g + 1];
      end else begin : g_top
         assign entries_up[g] = '0;
      end
   end

   // Oldest-ready selection from registered state only.
   // NOTE: every variable driven in always_comb gets a default first, so no path leaves it holding a stale value (latch).
   always_comb begin
      ready   = '0;
      sel_idx = '0;
      for (int i = RS_SIZE - 1; i >= 0; i--) begin
         ready[i] = entries[i].valid & entries[i].src1_valid & entries[i].src2_valid;
         if (ready[i]) sel_idx = IW'(i);
      end
   end

   assign insn_ready    = |ready;
   assign sel_entry     = entries[sel_idx];
   assign issue_rob_tag = insn_ready ? sel_entry.rob_tag    : '0;
   assign issue_func    = insn_ready ? sel_entry.func       : '0;
   assign issue_src1    = insn_ready ? sel_entry.src1_value : '0;
   assign issue_src2    = insn_ready ? sel_entry.src2_value : '0;

   assign rs_full     = (count == CW'(RS_SIZE));
   assign issue_fire  = issue & insn_ready;
   assign dispatch_ok = dispatch_valid & ~rs_full;

   // Build the entry being dispatched, optionally capturing a same-cycle CDB result.
   always_comb begin
      disp_entry            = '0;
      disp_entry.valid      = 1'b1;
      disp_entry.rob_tag    = dispatch_rob_tag;
      disp_entry.func       = dispatch_func;
      disp_entry.src1_valid = dispatch_src1_valid;
      disp_entry.src1_value = dispatch_src1_value;
      disp_entry.src1_tag   = dispatch_src1_tag;
      disp_entry.src2_valid = dispatch_src2_valid;
      disp_entry.src2_value = dispatch_src2_value;
      disp_entry.src2_tag   = dispatch_src2_tag;
`ifdef RS_DISPATCH_BYPASS_EN
      if (cdb_valid && !dispatch_src1_valid && dispatch_src1_tag == cdb_tag) begin
         disp_entry.src1_valid = 1'b1;
         disp_entry.src1_value = cdb_value;
      end
      if (cdb_valid && !dispatch_src2_valid && dispatch_src2_tag == cdb_tag) begin
         disp_entry.src2_valid = 1'b1;
         disp_entry.src2_value = cdb_value;
      end
`endif
   end

   // Next queue state: collapse over the issued slot, wake up, then append.
   always_comb begin
      count_after_issue = count - CW'(issue_fire);
      count_next        = count_after_issue + CW'(dispatch_ok);
      for (int i = 0; i < RS_SIZE; i++) begin
         entries_next[i] = (issue_fire && i >= int'(sel_idx)) ? entries_up[i] : entries[i];
         if (cdb_valid && entries_next[i].valid) begin
            if (!entries_next[i].src1_valid && entries_next[i].src1_tag == cdb_tag) begin
               entries_next[i].src1_valid = 1'b1;
               entries_next[i].src1_value = cdb_value;
            end
            if (!entries_next[i].src2_valid && entries_next[i].src2_tag == cdb_tag) begin
               entries_next[i].src2_valid = 1'b1;
               entries_next[i].src2_value = cdb_value;
            end
         end
         if (dispatch_ok && i == int'(count_after_issue)) entries_next[i] = disp_entry;
      end
   end

   // State register; reset and squash only clear occupancy.
   // NOTE: only the valid bits are reset; payload fields are don't-care while invalid, so they carry no reset.
   always_ff @(posedge clk) begin
      if (reset || squash) begin
         count <= '0;
         for (int i = 0; i < RS_SIZE; i++) entries[i].valid <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         count <= count_next;
         for (int i = 0; i < RS_SIZE; i++) entries[i] <= entries_next[i];
      end
   end

endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station: directed self-checking bench with an issue-order scoreboard.

module tb_reservation_station;

   localparam int RS_SIZE  = 4;
   localparam int TAG_LEN  = 6;
   localparam int DATA_LEN = 32;
   localparam int FUNC_LEN = 5;

   typedef struct {
      logic [TAG_LEN-1:0]  tag;
      logic [FUNC_LEN-1:0] func;
      logic [DATA_LEN-1:0] src1;
      logic [DATA_LEN-1:0] src2;
   } exp_t;

   logic                clk = 1'b0;
   logic                reset;
   logic                squash;
   logic                dispatch_valid;
   logic [TAG_LEN-1:0]  dispatch_rob_tag;
   logic [FUNC_LEN-1:0] dispatch_func;
   logic                dispatch_src1_valid;
   logic [DATA_LEN-1:0] dispatch_src1_value;
   logic [TAG_LEN-1:0]  dispatch_src1_tag;
   logic                dispatch_src2_valid;
   logic [DATA_LEN-1:0] dispatch_src2_value;
   logic [TAG_LEN-1:0]  dispatch_src2_tag;
   logic                rs_full;
   logic                cdb_valid;
   logic [TAG_LEN-1:0]  cdb_tag;
   logic [DATA_LEN-1:0] cdb_value;
   logic                insn_ready;
   logic                issue;
   logic [TAG_LEN-1:0]  issue_rob_tag;
   logic [FUNC_LEN-1:0] issue_func;
   logic [DATA_LEN-1:0] issue_src1;
   logic [DATA_LEN-1:0] issue_src2;

   int   checks = 0;
   int   errors = 0;
   exp_t sb [$];

   reservation_station #(
      .RS_SIZE (RS_SIZE),
      .TAG_LEN (TAG_LEN),
      .DATA_LEN(DATA_LEN),
      .FUNC_LEN(FUNC_LEN)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .squash             (squash),
      .dispatch_valid     (dispatch_valid),
      .dispatch_rob_tag   (dispatch_rob_tag),
      .dispatch_func      (dispatch_func),
      .dispatch_src1_valid(dispatch_src1_valid),
      .dispatch_src1_value(dispatch_src1_value),
      .dispatch_src1_tag  (dispatch_src1_tag),
      .dispatch_src2_valid(dispatch_src2_valid),
      .dispatch_src2_value(dispatch_src2_value),
      .dispatch_src2_tag  (dispatch_src2_tag),
      .rs_full            (rs_full),
      .cdb_valid          (cdb_valid),
      .cdb_tag            (cdb_tag),
      .cdb_value          (cdb_value),
      .insn_ready         (insn_ready),
      .issue              (issue),
      .issue_rob_tag      (issue_rob_tag),
      .issue_func         (issue_func),
      .issue_src1         (issue_src1),
      .issue_src2         (issue_src2)
   );

   always #5 clk = ~clk;

   // Advance one edge; inputs change and outputs are sampled 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", name, observed, expected);
      end
   endtask

   task automatic set_dispatch(input logic [TAG_LEN-1:0] tag, input logic [FUNC_LEN-1:0] func,
                               input logic s1v, input logic [DATA_LEN-1:0] s1, input logic [TAG_LEN-1:0] s1t,
                               input logic s2v, input logic [DATA_LEN-1:0] s2, input logic [TAG_LEN-1:0] s2t);
      dispatch_valid      = 1'b1;
      dispatch_rob_tag    = tag;
      dispatch_func       = func;
      dispatch_src1_valid = s1v;
      dispatch_src1_value = s1;
      dispatch_src1_tag   = s1t;
      dispatch_src2_valid = s2v;
      dispatch_src2_value = s2;
      dispatch_src2_tag   = s2t;
   endtask

   // Single-cycle dispatch of an entry with both operands already valid.
   task automatic dispatch_ready(input logic [TAG_LEN-1:0] tag, input logic [FUNC_LEN-1:0] func,
                                 input logic [DATA_LEN-1:0] s1, input logic [DATA_LEN-1:0] s2);
      set_dispatch(tag, func, 1'b1, s1, '0, 1'b1, s2, '0);
      tick();
      dispatch_valid = 1'b0;
   endtask

   task automatic push(input logic [TAG_LEN-1:0] tag, input logic [FUNC_LEN-1:0] func,
                       input logic [DATA_LEN-1:0] s1, input logic [DATA_LEN-1:0] s2);
      exp_t e;
      e.tag  = tag;
      e.func = func;
      e.src1 = s1;
      e.src2 = s2;
      sb.push_back(e);
   endtask

   // Compare the presented payload against the scoreboard head, then strobe issue.
   task automatic do_issue();
      exp_t e;
      check("insn_ready_before_issue", {63'd0, insn_ready}, 64'd1);
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL scoreboard_empty: observed issue of tag %0h expected no entry", issue_rob_tag);
      end else begin
         e = sb.pop_front();
         check("issue_rob_tag", {58'd0, issue_rob_tag}, {58'd0, e.tag});
         check("issue_func",    {59'd0, issue_func},    {59'd0, e.func});
         check("issue_src1",    {32'd0, issue_src1},    {32'd0, e.src1});
         check("issue_src2",    {32'd0, issue_src2},    {32'd0, e.src2});
      end
      issue = 1'b1;
      tick();
      issue = 1'b0;
   endtask

   initial begin
      reset          = 1'b1;
      squash         = 1'b0;
      issue          = 1'b0;
      cdb_valid      = 1'b0;
      cdb_tag        = '0;
      cdb_value      = '0;
      set_dispatch('0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
      dispatch_valid = 1'b0;
      tick();
      tick();
      reset = 1'b0;

      // Reset state.
      check("reset_rs_full",    {63'd0, rs_full},        64'd0);
      check("reset_insn_ready", {63'd0, insn_ready},     64'd0);
      check("reset_rob_tag",    {58'd0, issue_rob_tag},  64'd0);
      check("reset_func",       {59'd0, issue_func},     64'd0);
      check("reset_src1",       {32'd0, issue_src1},     64'd0);
      check("reset_src2",       {32'd0, issue_src2},     64'd0);

      // Single ready dispatch then issue.
      dispatch_ready(6'd3, 5'd1, 32'd5, 32'd7);
      push(6'd3, 5'd1, 32'd5, 32'd7);
      do_issue();
      check("t1_empty_after_issue", {63'd0, insn_ready}, 64'd0);

      // Three entries waiting on tag 9, woken by one broadcast.
      for (int t = 1; t <= 3; t++) begin
         set_dispatch(TAG_LEN'(t), 5'd2, 1'b1, 32'(t * 16), '0, 1'b0, '0, 6'd9);
         tick();
      end
      dispatch_valid = 1'b0;
      check("t2_waiting_not_ready", {63'd0, insn_ready}, 64'd0);
      cdb_valid = 1'b1;
      cdb_tag   = 6'd9;
      cdb_value = 32'hAB;
      tick();
      cdb_valid = 1'b0;
      for (int t = 1; t <= 3; t++) push(TAG_LEN'(t), 5'd2, 32'(t * 16), 32'hAB);
      for (int t = 1; t <= 3; t++) do_issue();
      check("t2_drained", {63'd0, insn_ready}, 64'd0);

      // Fill to full, dropped dispatch, order preserved.
      for (int t = 10; t <= 13; t++) begin
         dispatch_ready(TAG_LEN'(t), 5'd3, 32'(t), 32'(t + 100));
         push(TAG_LEN'(t), 5'd3, 32'(t), 32'(t + 100));
         if (t == 12) check("t3_not_full_at_3", {63'd0, rs_full}, 64'd0);
      end
      check("t3_full", {63'd0, rs_full}, 64'd1);
      dispatch_ready(6'd7, 5'd9, 32'h77, 32'h77);
      check("t3_still_full", {63'd0, rs_full}, 64'd1);
      do_issue();
      check("t3_not_full_after_issue", {63'd0, rs_full}, 64'd0);
      for (int k = 0; k < 3; k++) do_issue();
      check("t3_dropped_never_seen", {63'd0, insn_ready}, 64'd0);

      // Older waiting entry is bypassed by a younger ready one.
      set_dispatch(6'd20, 5'd4, 1'b1, 32'h20, '0, 1'b0, '0, 6'd4);
      tick();
      dispatch_ready(6'd6, 5'd5, 32'h60, 32'h61);
      push(6'd6, 5'd5, 32'h60, 32'h61);
      do_issue();
      check("t4_tag4_resident_not_ready", {63'd0, insn_ready}, 64'd0);
      cdb_valid = 1'b1;
      cdb_tag   = 6'd4;
      cdb_value = 32'h44;
      tick();
      cdb_valid = 1'b0;
      push(6'd20, 5'd4, 32'h20, 32'h44);
      do_issue();

      // Issue, wakeup of the shifting entry and dispatch in the same cycle.
      dispatch_ready(6'd50, 5'd6, 32'h50, 32'h51);
      set_dispatch(6'd51, 5'd7, 1'b0, '0, 6'd12, 1'b1, 32'h52, '0);
      tick();
      push(6'd50, 5'd6, 32'h50, 32'h51);
      set_dispatch(6'd52, 5'd8, 1'b1, 32'h53, '0, 1'b1, 32'h54, '0);
      cdb_valid = 1'b1;
      cdb_tag   = 6'd12;
      cdb_value = 32'h77;
      do_issue();
      cdb_valid      = 1'b0;
      dispatch_valid = 1'b0;
      push(6'd51, 5'd7, 32'h77, 32'h52);
      push(6'd52, 5'd8, 32'h53, 32'h54);
      do_issue();
      do_issue();
      check("t7_drained", {63'd0, insn_ready}, 64'd0);

      // Squash with dispatch and CDB active.
      for (int t = 30; t <= 32; t++) dispatch_ready(TAG_LEN'(t), 5'd1, 32'(t), 32'(t));
      set_dispatch(6'd33, 5'd1, 1'b1, 32'h33, '0, 1'b1, 32'h33, '0);
      cdb_valid = 1'b1;
      cdb_tag   = 6'd2;
      cdb_value = 32'h99;
      squash    = 1'b1;
      tick();
      squash         = 1'b0;
      cdb_valid      = 1'b0;
      dispatch_valid = 1'b0;
      check("t5_squash_insn_ready", {63'd0, insn_ready},    64'd0);
      check("t5_squash_rs_full",    {63'd0, rs_full},       64'd0);
      check("t5_squash_rob_tag",    {58'd0, issue_rob_tag}, 64'd0);
      for (int t = 40; t <= 42; t++) dispatch_ready(TAG_LEN'(t), 5'd1, 32'(t), 32'(t));
      check("t5_count_zero_after_squash", {63'd0, rs_full}, 64'd0);
      dispatch_ready(6'd43, 5'd1, 32'h43, 32'h43);
      check("t5_full_after_four", {63'd0, rs_full}, 64'd1);
      squash = 1'b1;
      tick();
      squash = 1'b0;
      check("t5_second_squash", {63'd0, rs_full}, 64'd0);

      // Same-cycle CDB and dispatch of a consumer.
      set_dispatch(6'd40, 5'd2, 1'b0, '0, 6'd5, 1'b1, 32'h22, '0);
      cdb_valid = 1'b1;
      cdb_tag   = 6'd5;
      cdb_value = 32'h11;
      tick();
      cdb_valid      = 1'b0;
      dispatch_valid = 1'b0;
`ifdef RS_DISPATCH_BYPASS_EN
      push(6'd40, 5'd2, 32'h11, 32'h22);
      do_issue();
`else
      check("t6_no_bypass_not_ready", {63'd0, insn_ready}, 64'd0);
      cdb_valid = 1'b1;
      cdb_tag   = 6'd5;
      cdb_value = 32'h12;
      tick();
      cdb_valid = 1'b0;
      push(6'd40, 5'd2, 32'h12, 32'h22);
      do_issue();
`endif
      check("t6_drained", {63'd0, insn_ready}, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
